// File: rtl/delay_probe_pkg.sv
// rtl/delay_probe_pkg.sv - shared types and constants for the delay-line probe
package delay_probe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WIDTH = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int SYNC_STAGES = 2;

  // All-ones value of a w-bit counter, reported as the latency on timeout.
  function automatic logic [31:0] lat_all_ones(input int w);
    logic [32:0] one_hot;
    one_hot = 33'd1 << w;
    return 32'(one_hot - 33'd1);
  endfunction

endpackage

// File: rtl/probe_sync.sv
// rtl/probe_sync.sv - two-flop synchronizer for the returned probe, resets to the line idle level (1)
module probe_sync
  import delay_probe_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/delay_line_probe.sv
// rtl/delay_line_probe.sv - launches a low test pulse into the delay line and measures latency and returned width
// DELAY_PROBE_SYNC_EN: synchronize probe_in through probe_sync and subtract its two cycles from the latency.
module delay_line_probe
  import delay_probe_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int TIMEOUT   = 255,
  parameter int PULSE_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             probe_out,
  input  logic             probe_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] latency,
  output logic             timeout,
  output logic             err
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] PULSE_C   = CNT_W'(PULSE_LEN);
  localparam logic [CNT_W-1:0] LAT_ONES  = CNT_W'(lat_all_ones(CNT_W));

  state_e           state_q, state_d;
  logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [CNT_W-1:0] wid_cnt_q, wid_cnt_d;
  logic             probe_out_q, probe_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] latency_q, latency_d;
  logic             timeout_q, timeout_d;
  logic             err_q, err_d;
  logic             line_in;
  logic [CNT_W-1:0] lat_comp;
  logic [CNT_W-1:0] pulse_nxt;

`ifdef DELAY_PROBE_SYNC_EN
  probe_sync u_probe_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (probe_in),
    .q     (line_in)
  );

  // The synchronizer adds its own stages to every raw count; remove them, floored at 0.
  always_comb begin
    lat_comp = (lat_cnt_q >= CNT_W'(SYNC_STAGES)) ? (lat_cnt_q - CNT_W'(SYNC_STAGES)) : '0;
  end
`else
  assign line_in = probe_in;

  always_comb begin
    lat_comp = lat_cnt_q;
  end
`endif

  always_comb begin
    pulse_nxt = (pulse_cnt_q < PULSE_C) ? (pulse_cnt_q + 1'b1) : pulse_cnt_q;
  end

  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    wid_cnt_d   = wid_cnt_q;
    probe_out_d = probe_out_q;
    latency_d   = latency_q;
    timeout_d   = timeout_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        probe_out_d = 1'b1;
        if (start) begin
          if (!line_in) begin
            state_d   = DONE;
            err_d     = 1'b1;
            latency_d = '0;
            timeout_d = 1'b0;
          end else begin
            state_d     = RUN;
            lat_cnt_d   = '0;
            pulse_cnt_d = '0;
            wid_cnt_d   = '0;
            probe_out_d = 1'b0;
          end
        end
      end

      RUN: begin
        pulse_cnt_d = pulse_nxt;
        probe_out_d = (pulse_nxt >= PULSE_C);
        if (!line_in) begin
          wid_cnt_d = CNT_W'(1);
          state_d   = WIDTH;
        end else if (lat_cnt_q == TIMEOUT_C) begin
          timeout_d   = 1'b1;
          latency_d   = LAT_ONES;
          err_d       = 1'b0;
          probe_out_d = 1'b1;
          state_d     = DONE;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end

      // lat_cnt is frozen here and holds the captured latency.
      WIDTH: begin
        pulse_cnt_d = pulse_nxt;
        probe_out_d = (pulse_nxt >= PULSE_C);
        if (line_in) begin
          err_d       = (wid_cnt_q != PULSE_C);
          latency_d   = lat_comp;
          timeout_d   = 1'b0;
          probe_out_d = 1'b1;
          state_d     = DONE;
        end else if (wid_cnt_q == TIMEOUT_C) begin
          err_d       = 1'b1;
          latency_d   = lat_comp;
          timeout_d   = 1'b0;
          probe_out_d = 1'b1;
          state_d     = DONE;
        end else begin
          wid_cnt_d = wid_cnt_q + 1'b1;
        end
      end

      DONE: begin
        probe_out_d = 1'b1;
        state_d     = IDLE;
      end

      default: begin
        probe_out_d = 1'b1;
        state_d     = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lat_cnt_q   <= '0;
      pulse_cnt_q <= '0;
      wid_cnt_q   <= '0;
      probe_out_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      latency_q   <= '0;
      timeout_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      wid_cnt_q   <= wid_cnt_d;
      probe_out_q <= probe_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      latency_q   <= latency_d;
      timeout_q   <= timeout_d;
      err_q       <= err_d;
    end
  end

  assign probe_out = probe_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign latency   = latency_q;
  assign timeout   = timeout_q;
  assign err       = err_q;

endmodule

// File: tb/tb_delay_line_probe.sv
// tb/tb_delay_line_probe.sv - randomized bench for delay_line_probe against a register delay-line model
module tb_delay_line_probe;

  localparam int CNT_W     = 8;
  localparam int TIMEOUT   = 255;
  localparam int PULSE_LEN = 4;
`ifdef DELAY_PROBE_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  localparam int M_NORM  = 0;
  localparam int M_SWAL  = 1;
  localparam int M_STRE  = 2;
  localparam int M_STUCK = 3;
  localparam int M_HIGH  = 4;
  localparam int M_LOW   = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             probe_out;
  logic             probe_in;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] latency;
  logic             timeout;
  logic             err;

  int checks   = 0;
  int failures = 0;

  // Line model: sr[d-1] is probe_out delayed by d cycles, every stage resets to 1.
  logic [299:0] sr;
  logic         stuck;
  logic         line_clr;
  int           mode;
  int           n;
  logic         t_n, t_nm1, t_np1;

  delay_line_probe #(
    .CNT_W     (CNT_W),
    .TIMEOUT   (TIMEOUT),
    .PULSE_LEN (PULSE_LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .probe_out (probe_out),
    .probe_in  (probe_in),
    .busy      (busy),
    .done      (done),
    .latency   (latency),
    .timeout   (timeout),
    .err       (err)
  );

  always #5 clk = ~clk;

  always_comb begin
    t_n   = (n == 0) ? probe_out : sr[n-1];
    t_nm1 = (n <= 1) ? probe_out : sr[n-2];
    t_np1 = sr[n];
    case (mode)
      M_NORM:  probe_in = t_n;
      M_SWAL:  probe_in = t_n | t_nm1;
      M_STRE:  probe_in = t_n & t_np1;
      M_STUCK: probe_in = t_n & ~stuck;
      M_LOW:   probe_in = 1'b0;
      default: probe_in = 1'b1;
    endcase
  end

  always @(posedge clk) begin
    if (line_clr) begin
      sr    <= '1;
      stuck <= 1'b0;
    end else begin
      sr <= {sr[298:0], probe_out};
      if (mode == M_STUCK && !t_n) stuck <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_probe_out"}, 32'(probe_out), 32'd1);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
    check({tag, "_latency"},   32'(latency),   32'd0);
    check({tag, "_timeout"},   32'(timeout),   32'd0);
    check({tag, "_err"},       32'(err),       32'd0);
  endtask

  // Expected results come straight from the line behaviour: returned width W, depth nn.
  task automatic run_one(input string tag, input int md, input int nn, input bit repulse);
    int w, exp_lat, exp_err, exp_to, exp_k, exp_lows;
    int lows, dones, done_k, first_low;
    w = PULSE_LEN;
    exp_lat = nn; exp_to = 0; exp_lows = PULSE_LEN; exp_k = -1; exp_err = 0;
    case (md)
      M_NORM:  begin w = PULSE_LEN;     exp_k = nn + w + 2 + SYNC; end
      M_SWAL:  begin w = PULSE_LEN - 1; exp_k = nn + w + 2 + SYNC; end
      M_STRE:  begin w = PULSE_LEN + 1; exp_k = nn + w + 2 + SYNC; end
      M_STUCK: begin exp_err = 1; end
      M_HIGH:  begin exp_lat = (1 << CNT_W) - 1; exp_to = 1; exp_k = TIMEOUT + 2; end
      default: begin exp_lat = 0; exp_err = 1; exp_k = 1; exp_lows = 0; end
    endcase
    if (md <= M_STRE) exp_err = (w != PULSE_LEN) ? 1 : 0;

    mode = md;
    n = nn;
    line_clr = 1'b1;
    @(posedge clk); #1;
    line_clr = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    lows = 0; dones = 0; done_k = -1; first_low = -1;
    for (int i = 1; i <= 700; i++) begin
      @(posedge clk); #1;
      if (i == 1) start = 1'b0;
      if (repulse && i == 3) start = 1'b1;
      if (repulse && i == 4) start = 1'b0;
      if (!probe_out) begin
        lows++;
        if (first_low < 0) first_low = i;
      end
      if (done) begin
        dones++;
        if (done_k < 0) done_k = i;
      end
      if (done_k >= 0 && i >= done_k + 3) break;
    end
    start = 1'b0;
    check({tag, "_done_count"}, 32'(dones), 32'd1);
    check({tag, "_latency"}, 32'(latency), 32'(exp_lat));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_timeout"}, 32'(timeout), 32'(exp_to));
    check({tag, "_pulse_cycles"}, 32'(lows), 32'(exp_lows));
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    if (exp_lows > 0) check({tag, "_pulse_start"}, 32'(first_low), 32'd1);
    if (exp_k >= 0) check({tag, "_done_time"}, 32'(done_k), 32'(exp_k));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode = M_HIGH;
    n = 0;
    line_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    line_clr = 1'b0;

    run_one("n100",     M_NORM, 100, 1'b0);
    run_one("n1",       M_NORM, 1,   1'b0);
    run_one("n0",       M_NORM, 0,   1'b0);
    run_one("tied_hi",  M_HIGH, 0,   1'b0);
    run_one("swallow",  M_SWAL, 100, 1'b0);
    run_one("stretch",  M_STRE, 100, 1'b0);
    run_one("stuck",    M_STUCK, 100, 1'b0);
    run_one("not_idle", M_LOW,  0,   1'b0);
    run_one("repulse",  M_NORM, 100, 1'b1);

    for (int r = 0; r < 8; r++) begin
      run_one($sformatf("rand%0d", r), int'($urandom_range(0, 2)),
              int'($urandom_range(1, 150)), 1'($urandom_range(0, 1)));
    end

    mode = M_NORM;
    n = 100;
    line_clr = 1'b1;
    @(posedge clk); #1;
    line_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("mid_reset");
    rst_n = 1'b1;
    run_one("after_reset", M_NORM, 100, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
